issue_scoreboard: RTL

- Stage directly downstream of the decode queue. Consumes the queue head micro-op and checks RAW/WAW hazards against a per-register busy scoreboard.
- Launches hazard-free micro-ops into a registered issue slot that feeds the execute stage.
- Generates the `stall` that freezes the decode queue. Clears busy bits on writeback.

---
 rtl/issue_scoreboard.sv | 95 +++++++++
 1 files changed

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: RAW/WAW hazard check of the decode-queue head against a busy scoreboard,
// launching hazard-free micro-ops into a registered issue slot.
module issue_scoreboard #(
   parameter int REG_ADDR_W = 4,
   parameter int MICRO_W    = 6,
   parameter int IMM_W      = 16,
   parameter int BIT_MODE_W = 2,
   parameter int ADDR_W     = 32,
   parameter int INFL_MAX   = 8,
   parameter int INFL_W     = 4,
   parameter int REG_N      = 2**REG_ADDR_W,
   parameter logic [MICRO_W-1:0] MICRO_NOP = '0
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [MICRO_W-1:0]    deq_opcode_head,
   input  logic [REG_ADDR_W-1:0] deq_reg_addr_d_head,
   input  logic [REG_ADDR_W-1:0] deq_reg_addr_s_head,
   input  logic [REG_ADDR_W-1:0] deq_reg_addr_t_head,
   input  logic [IMM_W-1:0]      deq_immediate_head,
   input  logic [BIT_MODE_W-1:0] deq_bit_mode_head,
   input  logic [ADDR_W-1:0]     deq_pc_head,
   input  logic                  deq_writes_d_head,
   input  logic                  deq_reads_s_head,
   input  logic                  deq_reads_t_head,
   input  logic                  exe_ready,
   input  logic                  wb_en,
   input  logic [REG_ADDR_W-1:0] wb_reg_addr,
   input  logic                  flush,
   output logic                  stall,
   output logic                  iss_valid,
   output logic [MICRO_W-1:0]    iss_opcode,
   output logic [REG_ADDR_W-1:0] iss_reg_addr_d,
   output logic [REG_ADDR_W-1:0] iss_reg_addr_s,
   output logic [REG_ADDR_W-1:0] iss_reg_addr_t,
   output logic [IMM_W-1:0]      iss_immediate,
   output logic [BIT_MODE_W-1:0] iss_bit_mode,
   output logic [ADDR_W-1:0]     iss_pc,
   output logic                  iss_writes_d
);
   logic [REG_N-1:0]  busy_q, busy_d, busy_eff, wb_mask, set_mask;
   logic [INFL_W-1:0] infl_q, infl_d;
   logic head_vld, hazard, slot_free, full, issue;
   // a register written back this cycle is already free for the head (bypass)
   assign wb_mask   = {{(REG_N-1){1'b0}}, wb_en} << wb_reg_addr;
   assign busy_eff  = busy_q & ~wb_mask;
   assign head_vld  = deq_opcode_head != MICRO_NOP;
   assign hazard    = (deq_reads_s_head & busy_eff[deq_reg_addr_s_head]) |
                      (deq_reads_t_head & busy_eff[deq_reg_addr_t_head]) |
                      (deq_writes_d_head & busy_eff[deq_reg_addr_d_head]);
   assign slot_free = ~iss_valid | exe_ready;
   assign full      = deq_writes_d_head & (infl_q == INFL_W'(INFL_MAX)) & ~wb_en;
   assign stall     = head_vld & (hazard | ~slot_free | full);
   assign issue     = head_vld & ~stall & ~flush;
   // set after clear so a new producer of the written-back register stays outstanding
   assign set_mask  = {{(REG_N-1){1'b0}}, issue & deq_writes_d_head} << deq_reg_addr_d_head;
   assign busy_d    = busy_eff | set_mask;
   assign infl_d    = infl_q + INFL_W'(issue & deq_writes_d_head) - INFL_W'(wb_en & (infl_q != '0));
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         iss_valid      <= 1'b0;
         iss_opcode     <= MICRO_NOP;
         iss_reg_addr_d <= '0;
         iss_reg_addr_s <= '0;
         iss_reg_addr_t <= '0;
         iss_immediate  <= '0;
         iss_bit_mode   <= '0;
         iss_pc         <= '0;
         iss_writes_d   <= 1'b0;
         busy_q         <= '0;
         infl_q         <= '0;
      end else if (flush) begin
         iss_valid  <= 1'b0;
         iss_opcode <= MICRO_NOP;
         busy_q     <= '0;
         infl_q     <= '0;
      end else begin
         busy_q <= busy_d;
         infl_q <= infl_d;
         if (issue) begin
            iss_valid      <= 1'b1;
            iss_opcode     <= deq_opcode_head;
            iss_reg_addr_d <= deq_reg_addr_d_head;
            iss_reg_addr_s <= deq_reg_addr_s_head;
            iss_reg_addr_t <= deq_reg_addr_t_head;
            iss_immediate  <= deq_immediate_head;
            iss_bit_mode   <= deq_bit_mode_head;
            iss_pc         <= deq_pc_head;
            iss_writes_d   <= deq_writes_d_head;
         end else if (exe_ready) begin
            iss_valid <= 1'b0;
         end
      end
   end
endmodule
